// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl -- PS/2 keyboard receive controller.
//
// This block synchronises the raw keyboard clock and data pins and captures
// 11-bit PS/2 frames. It checks the parity bit, the stop bit and a timeout
// between clock edges. The E0 and F0 prefix bytes are folded into
// Extended/Break flags, and decoded scan codes are buffered in a
// first-word-fall-through FIFO.
//
// Optional feature: define PS2_GLITCH_FILTER_EN to require the synchronised
// keyboard clock to hold a new level for 4 Clk cycles before it is accepted.
// This adds 3 cycles of edge latency.
//
// Ports:
//   Clk        system clock
//   Rst        asynchronous active-low reset
//   KbdClockIn raw PS/2 clock (asynchronous)
//   KbdDataIn  raw PS/2 data (asynchronous)
//   RdEn       pop FIFO head (ignored while empty)
//   ClrErr     clear sticky Overflow
//   Valid      FIFO not empty
//   ScanCode   head scan code (0 when empty)
//   Break      head code preceded by F0 (0 when empty)
//   Extended   head code preceded by E0 (0 when empty)
//   FifoFull   FIFO holds FIFO_DEPTH entries
//   ParityErr  one-cycle pulse on bad parity
//   FrameErr   one-cycle pulse on bad stop bit or timeout
//   Overflow   sticky, a good code was dropped on a full FIFO
module ps2_kbd_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       KbdClockIn,
  input  logic       KbdDataIn,
  input  logic       RdEn,
  input  logic       ClrErr,
  output logic       Valid,
  output logic [7:0] ScanCode,
  output logic       Break,
  output logic       Extended,
  output logic       FifoFull,
  output logic       ParityErr,
  output logic       FrameErr,
  output logic       Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} stateT;

  logic clkSync1, clkSync2, dataSync1, dataSync2;
  logic fallEdge, dataBit;

  // Two-flop synchronisers. They reset high because an idle PS/2 bus is high.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      clkSync1  <= 1'b1;
      clkSync2  <= 1'b1;
      dataSync1 <= 1'b1;
      dataSync2 <= 1'b1;
    end else begin
      clkSync1  <= KbdClockIn;
      clkSync2  <= clkSync1;
      dataSync1 <= KbdDataIn;
      dataSync2 <= dataSync1;
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  logic       filtClk;
  logic [1:0] filtCnt;
  logic [2:0] dataDly;

  // The filtered clock follows the synchronised clock only after 4 stable
  // cycles. The edge is flagged in the cycle just before the filtered level
  // flips, so the FSM acts 3 edges later than in the unfiltered build. Data
  // is delayed by the same 3 cycles so that it lines up with the clock.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      filtClk <= 1'b1;
      filtCnt <= 2'd0;
      dataDly <= 3'b111;
    end else begin
      dataDly <= {dataDly[1:0], dataSync2};
      if (clkSync2 == filtClk) begin
        filtCnt <= 2'd0;
      end else if (filtCnt == 2'd3) begin
        filtClk <= clkSync2;
        filtCnt <= 2'd0;
      end else begin
        filtCnt <= filtCnt + 2'd1;
      end
    end
  end

  assign fallEdge = filtClk & ~clkSync2 & (filtCnt == 2'd3);
  assign dataBit  = dataDly[2];
`else
  logic clkHist;

  // The history flop turns the synchronised clock into a falling-edge strobe.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) clkHist <= 1'b1;
    else      clkHist <= clkSync2;
  end

  assign fallEdge = clkHist & ~clkSync2;
  assign dataBit  = dataSync2;
`endif

  stateT         state, stateNext;
  logic [2:0]    bitCnt, bitCntNext;
  logic [7:0]    shiftReg, shiftNext;
  logic          parityBit, parityNext;
  logic          extFlag, extNext, brkFlag, brkNext;
  logic [TW-1:0] timeoutCnt, timeoutNext;
  logic          parityErrNext, frameErrNext, push;

  // Frame state and prefix flags are registered here.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      bitCnt     <= 3'd0;
      shiftReg   <= 8'd0;
      parityBit  <= 1'b0;
      extFlag    <= 1'b0;
      brkFlag    <= 1'b0;
      timeoutCnt <= '0;
      ParityErr  <= 1'b0;
      FrameErr   <= 1'b0;
    end else begin
      state      <= stateNext;
      bitCnt     <= bitCntNext;
      shiftReg   <= shiftNext;
      parityBit  <= parityNext;
      extFlag    <= extNext;
      brkFlag    <= brkNext;
      timeoutCnt <= timeoutNext;
      ParityErr  <= parityErrNext;
      FrameErr   <= frameErrNext;
    end
  end

  // This block computes the next state. A timeout takes priority over an
  // edge that arrives in the same cycle. Data bits shift in at the MSB, so
  // after eight bits the first (LSB-first) bit sits at bit 0.
  always_comb begin
    stateNext     = state;
    bitCntNext    = bitCnt;
    shiftNext     = shiftReg;
    parityNext    = parityBit;
    extNext       = extFlag;
    brkNext       = brkFlag;
    timeoutNext   = '0;
    parityErrNext = 1'b0;
    frameErrNext  = 1'b0;
    push          = 1'b0;
    if (state != IDLE && !fallEdge) timeoutNext = timeoutCnt + TW'(1);
    if (state != IDLE && timeoutCnt == TW'(TIMEOUT_CYCLES)) begin
      stateNext    = IDLE;
      frameErrNext = 1'b1;
      extNext      = 1'b0;
      brkNext      = 1'b0;
      timeoutNext  = '0;
    end else if (fallEdge) begin
      case (state)
        IDLE: begin
          if (!dataBit) begin
            stateNext  = DATA;
            bitCntNext = 3'd0;
          end
        end
        DATA: begin
          shiftNext  = {dataBit, shiftReg[7:1]};
          bitCntNext = bitCnt + 3'd1;
          if (bitCnt == 3'd7) stateNext = PARITY;
        end
        PARITY: begin
          parityNext = dataBit;
          stateNext  = STOP;
        end
        STOP: begin
          stateNext = IDLE;
          if (!dataBit) begin
            frameErrNext = 1'b1;
            extNext      = 1'b0;
            brkNext      = 1'b0;
          end else if ((^{shiftReg, parityBit}) == 1'b0) begin
            parityErrNext = 1'b1;
            extNext       = 1'b0;
            brkNext       = 1'b0;
          end else if (shiftReg == 8'hE0) begin
            extNext = 1'b1;
          end else if (shiftReg == 8'hF0) begin
            brkNext = 1'b1;
          end else begin
            push    = 1'b1;
            extNext = 1'b0;
            brkNext = 1'b0;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic [9:0]    head;
  logic          pop, doPush, ovfSet;

  assign Valid    = (count != '0);
  assign FifoFull = (count == CW'(FIFO_DEPTH));
  assign pop      = RdEn & Valid;
  assign doPush   = push & (~FifoFull | pop);
  assign ovfSet   = push & FifoFull & ~pop;
  assign head     = mem[rdPtr];
  assign ScanCode = Valid ? head[7:0] : 8'd0;
  assign Break    = Valid & head[8];
  assign Extended = Valid & head[9];

  // FIFO storage needs no reset because the head outputs are gated by Valid.
  always_ff @(posedge Clk) begin
    if (doPush) mem[wrPtr] <= {extFlag, brkFlag, shiftReg};
  end

  // FIFO pointers, occupancy and sticky overflow. The set of Overflow wins
  // over a clear in the same cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (pop)    rdPtr <= rdPtr + AW'(1);
      case ({doPush, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovfSet)      Overflow <= 1'b1;
      else if (ClrErr) Overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl -- self-checking bench for ps2_kbd_ctrl.
// A behavioural model applies the PS/2 frame rules to each frame that is
// sent. It keeps a queue of expected FIFO entries and cumulative expected
// error-pulse counts. Each scenario task compares the DUT against the model.
module tb_ps2_kbd_ctrl;

  localparam int FifoDepth     = 8;
  localparam int TimeoutCycles = 300;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       KbdClockIn = 1'b1;
  logic       KbdDataIn = 1'b1;
  logic       RdEn = 1'b0;
  logic       ClrErr = 1'b0;
  logic       Valid, Break, Extended, FifoFull, ParityErr, FrameErr, Overflow;
  logic [7:0] ScanCode;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [9:0] modelQ[$];
  logic       mExt = 1'b0, mBrk = 1'b0, mOvf = 1'b0;
  int         expParityErr = 0, expFrameErr = 0;

  // Observed pulse statistics.
  int   parityPulses = 0, parityHigh = 0, framePulses = 0, frameHigh = 0;
  logic prevParity = 1'b0, prevFrame = 1'b0;

  ps2_kbd_ctrl #(.FIFO_DEPTH(FifoDepth), .TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .Clk(Clk), .Rst(Rst), .KbdClockIn(KbdClockIn), .KbdDataIn(KbdDataIn),
    .RdEn(RdEn), .ClrErr(ClrErr), .Valid(Valid), .ScanCode(ScanCode),
    .Break(Break), .Extended(Extended), .FifoFull(FifoFull),
    .ParityErr(ParityErr), .FrameErr(FrameErr), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  // Count rising edges and high cycles of the error pulses.
  always @(negedge Clk) begin
    if (ParityErr) parityHigh++;
    if (ParityErr && !prevParity) parityPulses++;
    if (FrameErr) frameHigh++;
    if (FrameErr && !prevFrame) framePulses++;
    prevParity = ParityErr;
    prevFrame  = FrameErr;
  end

  task automatic modelFrame(input logic [7:0] b, input logic parBit, input logic stopBit);
    if (!stopBit) begin
      expFrameErr++; mExt = 1'b0; mBrk = 1'b0;
    end else if ((^b ^ parBit) == 1'b0) begin
      expParityErr++; mExt = 1'b0; mBrk = 1'b0;
    end else if (b == 8'hE0) begin
      mExt = 1'b1;
    end else if (b == 8'hF0) begin
      mBrk = 1'b1;
    end else begin
      if (modelQ.size() < FifoDepth) modelQ.push_back({mExt, mBrk, b});
      else mOvf = 1'b1;
      mExt = 1'b0; mBrk = 1'b0;
    end
  endtask

  task automatic modelTimeout();
    expFrameErr++; mExt = 1'b0; mBrk = 1'b0;
  endtask

  task automatic sendBit(input logic d);
    KbdDataIn = d;
    repeat (5) @(negedge Clk);
    KbdClockIn = 1'b0;
    repeat (10) @(negedge Clk);
    KbdClockIn = 1'b1;
    repeat (5) @(negedge Clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit badParity, input bit badStop);
    logic parBit;
    parBit = ~(^b) ^ badParity;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(parBit);
    sendBit(~badStop);
    KbdDataIn = 1'b1;
    repeat (8) @(negedge Clk);
    modelFrame(b, parBit, ~badStop);
  endtask

  task automatic popHead();
    RdEn = 1'b1;
    @(negedge Clk);
    RdEn = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    #2 Rst = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({Valid, ScanCode, Break, Extended, FifoFull, ParityErr, FrameErr, Overflow} !== 15'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b required 0",
               {Valid, ScanCode, Break, Extended, FifoFull, ParityErr, FrameErr, Overflow});
    end
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_make_code();
    logic [9:0] e;
    applyStimulus(8'h1C, 1'b0, 1'b0);
    while (modelQ.size() > 0) begin
      e = modelQ.pop_front();
      checks++;
      if ({Valid, Extended, Break, ScanCode} !== {1'b1, e}) begin
        errors++;
        $display("[TB] FAIL make_head: got %h required %h", {Valid, Extended, Break, ScanCode}, {1'b1, e});
      end
      popHead();
    end
    checks++;
    if (Valid !== 1'b0 || ScanCode !== 8'd0) begin
      errors++;
      $display("[TB] FAIL make_empty: got Valid=%b ScanCode=%h required 0/00", Valid, ScanCode);
    end
  endtask

  task automatic test_prefixes();
    logic [9:0] e;
    applyStimulus(8'hE0, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0);
    applyStimulus(8'h75, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    while (modelQ.size() > 0) begin
      e = modelQ.pop_front();
      checks++;
      if ({Valid, Extended, Break, ScanCode} !== {1'b1, e}) begin
        errors++;
        $display("[TB] FAIL prefix_head: got %h required %h", {Valid, Extended, Break, ScanCode}, {1'b1, e});
      end
      popHead();
    end
    checks++;
    if ({Valid, Extended, Break, ScanCode} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL prefix_empty: got %h required 000", {Valid, Extended, Break, ScanCode});
    end
  endtask

  task automatic test_errors();
    applyStimulus(8'h1C, 1'b1, 1'b0);
    checks++;
    if (Valid !== 1'b0 || parityPulses != expParityErr) begin
      errors++;
      $display("[TB] FAIL parity_error: got Valid=%b pulses=%0d required 0/%0d", Valid, parityPulses, expParityErr);
    end
    applyStimulus(8'h1C, 1'b0, 1'b1);
    checks++;
    if (Valid !== 1'b0 || framePulses != expFrameErr) begin
      errors++;
      $display("[TB] FAIL stop_error: got Valid=%b pulses=%0d required 0/%0d", Valid, framePulses, expFrameErr);
    end
    checks++;
    if (parityHigh != parityPulses || frameHigh != framePulses) begin
      errors++;
      $display("[TB] FAIL pulse_width: got high=%0d/%0d pulses=%0d/%0d required equal",
               parityHigh, frameHigh, parityPulses, framePulses);
    end
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(b[i]);
    KbdDataIn = 1'b1;
    repeat (TimeoutCycles + 10) @(negedge Clk);
    modelTimeout();
    checks++;
    if (framePulses != expFrameErr || frameHigh != framePulses) begin
      errors++;
      $display("[TB] FAIL timeout_pulse: got pulses=%0d high=%0d required %0d", framePulses, frameHigh, expFrameErr);
    end
    applyStimulus(8'h29, 1'b0, 1'b0);
    while (modelQ.size() > 0) begin
      e = modelQ.pop_front();
      checks++;
      if ({Valid, Extended, Break, ScanCode} !== {1'b1, e}) begin
        errors++;
        $display("[TB] FAIL timeout_recover: got %h required %h", {Valid, Extended, Break, ScanCode}, {1'b1, e});
      end
      popHead();
    end
  endtask

  task automatic test_overflow();
    logic [9:0] e;
    for (int i = 1; i <= FifoDepth + 1; i++) applyStimulus(8'(i), 1'b0, 1'b0);
    checks++;
    if (FifoFull !== (modelQ.size() == FifoDepth) || Overflow !== mOvf) begin
      errors++;
      $display("[TB] FAIL overflow_flags: got full=%b ovf=%b required %b/%b",
               FifoFull, Overflow, modelQ.size() == FifoDepth, mOvf);
    end
    while (modelQ.size() > 0) begin
      e = modelQ.pop_front();
      checks++;
      if ({Valid, Extended, Break, ScanCode} !== {1'b1, e}) begin
        errors++;
        $display("[TB] FAIL overflow_order: got %h required %h", {Valid, Extended, Break, ScanCode}, {1'b1, e});
      end
      popHead();
    end
    checks++;
    if (FifoFull !== 1'b0 || Valid !== 1'b0 || Overflow !== mOvf) begin
      errors++;
      $display("[TB] FAIL overflow_drained: got full=%b valid=%b ovf=%b required 0/0/%b",
               FifoFull, Valid, Overflow, mOvf);
    end
    ClrErr = 1'b1;
    @(negedge Clk);
    ClrErr = 1'b0;
    mOvf = 1'b0;
    checks++;
    if (Overflow !== mOvf) begin
      errors++;
      $display("[TB] FAIL overflow_clear: got %b required %b", Overflow, mOvf);
    end
  endtask

  task automatic test_glitch();
    logic [9:0] e;
    KbdDataIn = 1'b0;
    repeat (3) @(negedge Clk);
    KbdClockIn = 1'b0;
    repeat (2) @(negedge Clk);
    KbdClockIn = 1'b1;
    repeat (3) @(negedge Clk);
    KbdDataIn = 1'b1;
    repeat (TimeoutCycles + 20) @(negedge Clk);
`ifndef PS2_GLITCH_FILTER_EN
    modelTimeout();
`endif
    checks++;
    if (framePulses != expFrameErr) begin
      errors++;
      $display("[TB] FAIL glitch_frame_err: got pulses=%0d required %0d", framePulses, expFrameErr);
    end
    applyStimulus(8'h1C, 1'b0, 1'b0);
    while (modelQ.size() > 0) begin
      e = modelQ.pop_front();
      checks++;
      if ({Valid, Extended, Break, ScanCode} !== {1'b1, e}) begin
        errors++;
        $display("[TB] FAIL glitch_recover: got %h required %h", {Valid, Extended, Break, ScanCode}, {1'b1, e});
      end
      popHead();
    end
  endtask

  task automatic test_random();
    logic [9:0] e;
    logic [7:0] b;
    int         sel;
    for (int round = 0; round < 4; round++) begin
      for (int f = 0; f < 6; f++) begin
        sel = $urandom_range(0, 5);
        b = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
        sel = $urandom_range(0, 9);
        applyStimulus(b, sel == 0, sel == 1);
      end
      while (modelQ.size() > 0) begin
        e = modelQ.pop_front();
        checks++;
        if ({Valid, Extended, Break, ScanCode} !== {1'b1, e}) begin
          errors++;
          $display("[TB] FAIL random_head: got %h required %h", {Valid, Extended, Break, ScanCode}, {1'b1, e});
        end
        popHead();
      end
      checks++;
      if (Valid !== 1'b0 || parityPulses != expParityErr || framePulses != expFrameErr) begin
        errors++;
        $display("[TB] FAIL random_errs: got valid=%b par=%0d frm=%0d required 0/%0d/%0d",
                 Valid, parityPulses, framePulses, expParityErr, expFrameErr);
      end
    end
    checks++;
    if (parityHigh != parityPulses || frameHigh != framePulses || Overflow !== mOvf) begin
      errors++;
      $display("[TB] FAIL random_pulse_width: got high=%0d/%0d pulses=%0d/%0d ovf=%b required equal/%b",
               parityHigh, frameHigh, parityPulses, framePulses, Overflow, mOvf);
    end
  endtask

  initial begin
    test_reset();
    test_make_code();
    test_prefixes();
    test_errors();
    test_timeout();
    test_overflow();
    test_glitch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

PS/2 keyboard receive controller for the MAX10 board flow. It synchronises the raw keyboard clock and data pins and sequences the 11-bit PS/2 frame capture. It validates parity, stop bit and frame timeout, folds the E0/F0 prefix bytes into flags, and buffers decoded scan codes in a small FIFO. It replaces raw pin probing with a clean, handshaked scan-code stream for the core or the signal-tap harness.

## Interface
Parameters:
- FIFO_DEPTH, 8, number of decoded-code entries; power of 2, ≥2
- TIMEOUT_CYCLES, 50000, max Clk cycles between accepted falling edges inside a frame (1 ms at 50 MHz)

Ports:
- Clk  in  1  system clock, single clock domain
- Rst  in  1  asynchronous, active-low reset (asserted at 0)
- KbdClockIn  in  1  raw PS/2 clock from keyboard, asynchronous
- KbdDataIn  in  1  raw PS/2 data from keyboard, asynchronous
- RdEn  in  1  pop FIFO head; honoured only when Valid=1
- ClrErr  in  1  clears sticky Overflow
- Valid  out  1  FIFO not empty
- ScanCode  out  8  head scan code; 0 when Valid=0
- Break  out  1  head code was preceded by F0; 0 when Valid=0
- Extended  out  1  head code was preceded by E0; 0 when Valid=0
- FifoFull  out  1  FIFO holds FIFO_DEPTH entries
- ParityErr  out  1  one-cycle pulse, bad parity
- FrameErr  out  1  one-cycle pulse, bad stop bit or timeout
- Overflow  out  1  sticky, a good code was dropped because the FIFO was full

## Operation
- Both pins pass through 2-flop synchronisers plus a history flop. All synchroniser and history flops reset to 1 (idle bus high).
- A falling edge is history=1 and sync=0 on KbdClock. Data is taken from the equally delayed synchronised KbdData.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data=0 (start bit), go to DATA and set bit count to 0. A falling edge with data=1 is ignored.
  - DATA: shift in 8 bits LSB first, one per falling edge. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: on the next falling edge, evaluate the frame and return to IDLE.
- Frame evaluation, in priority order:
  - Stop bit 0: FrameErr pulse.
  - XOR of the 8 data bits and the parity bit equal to 0: ParityErr pulse.
  - Otherwise the byte is good.
- Good byte handling:
  - 0xE0 sets the ext flag.
  - 0xF0 sets the brk flag.
  - Any other byte pushes {ext, brk, byte} and clears both flags.
- Any error drops the byte and clears both flags.
- Timeout: outside IDLE, a counter of width $clog2(TIMEOUT_CYCLES+1) clears on each accepted falling edge. When it reaches TIMEOUT_CYCLES:
  - the frame is aborted and the FSM returns to IDLE;
  - FrameErr pulses;
  - both flags clear.
- FIFO:
  - Entries are 10 bits, first-word-fall-through. Head outputs are gated to 0 when empty.
  - Occupancy count is $clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
  - Push when full with no simultaneous pop: entry dropped, Overflow set.
  - Push and pop together when full: both happen, no overflow.
  - RdEn while empty is ignored.
  - Overflow clears on ClrErr. If an overflow and ClrErr occur in the same cycle, the set wins.
- Reset mid-frame: the partial frame, flags, FIFO and errors are cleared. Any trailing bits of that frame resolve through the ignore/timeout rules.

## Timing
- Reset values: Valid=0, ScanCode=0, Break=0, Extended=0, FifoFull=0, ParityErr=0, FrameErr=0, Overflow=0, FSM=IDLE.
- Edge latency: the FSM acts on Clk edge N+2, where edge N is the first Clk edge that samples KbdClockIn low.
- The FIFO write happens on edge N+2 of the stop bit. Valid, ScanCode and FifoFull update after that edge, visible in cycle N+3.
- A pop on edge M updates Valid and the head in cycle M+1.
- Error pulses are exactly 1 Clk cycle, registered on the evaluation or timeout edge.
- The PS/2 clock period must be ≥ 8 Clk cycles.

## Configuration
- PS2_GLITCH_FILTER_EN defined: the synchronised KbdClock must hold a new level for 4 consecutive Clk cycles before the filtered level changes.
  - Edge latency grows by 3 cycles, so the FSM acts on edge N+5.
  - Pulses of 3 cycles or fewer are ignored.
- Not defined: no filter; every synchronised transition counts.

## Test plan
- Make code: frame 0x1C with parity 0 and stop 1 → Valid=1, ScanCode=0x1C, Break=0, Extended=0. RdEn for one cycle → Valid=0.
- Prefixes: frames E0, F0, 75 → exactly one entry: ScanCode=0x75, Break=1, Extended=1. A following frame 0x1C gives an entry with both flags 0.
- Parity and stop errors:
  - 0x1C with parity 1 → one-cycle ParityErr, FIFO empty.
  - 0x1C with stop 0 → one-cycle FrameErr, FIFO empty.
- Timeout: start bit plus 4 data bits, then idle for TIMEOUT_CYCLES+10 → FrameErr pulse once. A following good frame 0x29 → ScanCode=0x29.
- Overflow: FIFO_DEPTH+1 frames 0x01..0x09 with no reads → FifoFull=1, Overflow=1. Reads return 0x01..0x08 in order. ClrErr → Overflow=0.
- Glitch: a 2-cycle low pulse on KbdClockIn with KbdDataIn=0 in IDLE.
  - With PS2_GLITCH_FILTER_EN: FSM stays IDLE; a following good frame 0x1C decodes correctly.
  - Without it: FSM leaves IDLE and FrameErr pulses at timeout.
